// File: rtl/mip_pkg.sv
// mip_pkg: shared types, constants and helpers for the MIP projection core.
//   mode_e     - density processing mode encoding
//   DROP_CNT_W - width of the saturating dropped-beat counter
//   sum_w()    - width of a row sum after the three-term dot product
//   sat_u()    - clamp a signed value into the unsigned range [0, 2^w-1]
package mip_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_INVERT = 2'd2
  } mode_e;

  localparam int DROP_CNT_W = 16;

  // Product is MAT_W+VOX_W+1 bits; summing three of them needs 2 more.
  function automatic int sum_w(input int mat_w, input int vox_w);
    return mat_w + vox_w + 3;
  endfunction

  function automatic longint sat_u(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << w) - longint'(1);
    if (v < 0)
      return 0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/mip_dot3.sv
// mip_dot3: signed three-term dot product of fixed-point coefficients with
// unsigned voxel axes, followed by an arithmetic shift and a constant offset.
//   clk_i          clock
//   en_i           pipeline advance enable shared with the core
//   c0_i..c2_i     signed coefficients (one matrix row)
//   v0_i..v2_i     unsigned voxel axes x, y, z
//   dot_o          registered result, valid two enabled cycles after input
module mip_dot3
  import mip_pkg::*;
#(
  parameter int VOX_W  = 8,
  parameter int MAT_W  = 8,
  parameter int FRAC_W = 6,
  parameter int OFF    = 0
) (
  input  logic                                     clk_i,
  input  logic                                     en_i,
  input  logic signed [MAT_W-1:0]                  c0_i,
  input  logic signed [MAT_W-1:0]                  c1_i,
  input  logic signed [MAT_W-1:0]                  c2_i,
  input  logic        [VOX_W-1:0]                  v0_i,
  input  logic        [VOX_W-1:0]                  v1_i,
  input  logic        [VOX_W-1:0]                  v2_i,
  output logic signed [sum_w(MAT_W, VOX_W)-1:0]    dot_o
);

  localparam int PW = MAT_W + VOX_W + 1;
  localparam int SW = sum_w(MAT_W, VOX_W);

  logic signed [PW-1:0] c_ext [3];
  logic signed [PW-1:0] v_ext [3];
  logic signed [PW-1:0] prod_p1_q [3];
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] dot_d;
  logic signed [SW-1:0] dot_p2_q;

  // Voxel axes are zero-extended so they stay positive in signed math.
  always_comb begin
    c_ext[0] = PW'(c0_i);
    c_ext[1] = PW'(c1_i);
    c_ext[2] = PW'(c2_i);
    v_ext[0] = $signed({{(PW-VOX_W){1'b0}}, v0_i});
    v_ext[1] = $signed({{(PW-VOX_W){1'b0}}, v1_i});
    v_ext[2] = $signed({{(PW-VOX_W){1'b0}}, v2_i});
  end

  // ---- S1: products ----
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      prod_p1_q[0] <= c_ext[0] * v_ext[0];
      prod_p1_q[1] <= c_ext[1] * v_ext[1];
      prod_p1_q[2] <= c_ext[2] * v_ext[2];
    end
  end

  // >>> on a signed value floors toward -inf, dropping the fraction bits.
  always_comb begin
    sum_d = SW'(prod_p1_q[0]) + SW'(prod_p1_q[1]) + SW'(prod_p1_q[2]);
    dot_d = (sum_d >>> FRAC_W) + SW'(OFF);
  end

  // ---- S2: sum, shift, offset ----
  always_ff @(posedge clk_i) begin
    if (en_i) dot_p2_q <= dot_d;
  end

  assign dot_o = dot_p2_q;

endmodule

// File: rtl/mip_project_core.sv
// mip_project_core: three-stage voxel-to-screen projection with density
// mode processing and a valid/ready output handshake.
//   clock, reset            clock; asynchronous active-high reset
//   in_valid/in_ready       input handshake (in_ready = pipeline enable)
//   in_voxelPos             packed {z,y,x}, unsigned
//   in_density              voxel density
//   in_mvpInfo_mat_r_c      signed fixed-point matrix, row r = output axis
//   in_mode/in_threshold    density mode (0 pass, 1 threshold, 2 invert)
//   in_countClear           synchronous clear of out_dropCount
//   out_valid/out_ready     output handshake
//   out_screenPos_x/_y      screen coordinates
//   out_depth, out_density  depth and processed density
//   out_dropCount           saturating dropped-beat count
// Build option: define MIP_CLIP_EN to drop off-screen beats instead of
// saturating x/y to the coordinate range.
module mip_project_core
  import mip_pkg::*;
#(
  parameter int VOX_W     = 8,
  parameter int MAT_W     = 8,
  parameter int FRAC_W    = 6,
  parameter int SCR_W     = 11,
  parameter int X_OFF     = 0,
  parameter int Y_OFF     = 0,
  parameter int SCR_X_MAX = 1919,
  parameter int SCR_Y_MAX = 1079
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*VOX_W-1:0]      in_voxelPos,
  input  logic [7:0]              in_density,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_0_0,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_0_1,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_0_2,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_1_0,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_1_1,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_1_2,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_2_0,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_2_1,
  input  logic signed [MAT_W-1:0] in_mvpInfo_mat_2_2,
  input  logic [1:0]              in_mode,
  input  logic [7:0]              in_threshold,
  input  logic                    in_countClear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SCR_W-1:0]        out_screenPos_x,
  output logic [SCR_W-1:0]        out_screenPos_y,
  output logic [SCR_W-1:0]        out_depth,
  output logic [7:0]              out_density,
  output logic [DROP_CNT_W-1:0]   out_dropCount
);

  localparam int SW = sum_w(MAT_W, VOX_W);

  logic                  en;
  logic [VOX_W-1:0]      vox_x, vox_y, vox_z;
  logic signed [SW-1:0]  dot_x_p2, dot_y_p2, dot_d_p2;

  logic                  vld_p1_q, vld_p2_q, vld_p3_q;
  logic [7:0]            dens_p1_q, dens_p2_q;
  logic [1:0]            mode_p1_q, mode_p2_q;
  logic [7:0]            thr_p1_q, thr_p2_q;

  logic [SCR_W-1:0]      x_q, y_q, depth_q;
  logic [7:0]            dens_q;
  logic [DROP_CNT_W-1:0] cnt_q;

  logic [SCR_W-1:0]      x_d, y_d, depth_d;
  logic [7:0]            dens_d;
  logic                  drop;
  longint                x_l, y_l, d_l;
  longint                x_sat, y_sat, d_sat;

  // A bubble in S3 never stalls the pipe.
  assign en       = !vld_p3_q || out_ready;
  assign in_ready = en;

  assign vox_x = in_voxelPos[VOX_W-1:0];
  assign vox_y = in_voxelPos[2*VOX_W-1:VOX_W];
  assign vox_z = in_voxelPos[3*VOX_W-1:2*VOX_W];

  mip_dot3 #(.VOX_W(VOX_W), .MAT_W(MAT_W), .FRAC_W(FRAC_W), .OFF(X_OFF)) u_row_x (
    .clk_i(clock), .en_i(en),
    .c0_i(in_mvpInfo_mat_0_0), .c1_i(in_mvpInfo_mat_0_1), .c2_i(in_mvpInfo_mat_0_2),
    .v0_i(vox_x), .v1_i(vox_y), .v2_i(vox_z), .dot_o(dot_x_p2)
  );

  mip_dot3 #(.VOX_W(VOX_W), .MAT_W(MAT_W), .FRAC_W(FRAC_W), .OFF(Y_OFF)) u_row_y (
    .clk_i(clock), .en_i(en),
    .c0_i(in_mvpInfo_mat_1_0), .c1_i(in_mvpInfo_mat_1_1), .c2_i(in_mvpInfo_mat_1_2),
    .v0_i(vox_x), .v1_i(vox_y), .v2_i(vox_z), .dot_o(dot_y_p2)
  );

  mip_dot3 #(.VOX_W(VOX_W), .MAT_W(MAT_W), .FRAC_W(FRAC_W), .OFF(0)) u_row_d (
    .clk_i(clock), .en_i(en),
    .c0_i(in_mvpInfo_mat_2_0), .c1_i(in_mvpInfo_mat_2_1), .c2_i(in_mvpInfo_mat_2_2),
    .v0_i(vox_x), .v1_i(vox_y), .v2_i(vox_z), .dot_o(dot_d_p2)
  );

  // ---- S1/S2: stage valids ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Density, mode and threshold travel alongside the beat.
  always_ff @(posedge clock) begin
    if (en) begin
      dens_p1_q <= in_density;
      mode_p1_q <= in_mode;
      thr_p1_q  <= in_threshold;
      dens_p2_q <= dens_p1_q;
      mode_p2_q <= mode_p1_q;
      thr_p2_q  <= thr_p1_q;
    end
  end

  always_comb begin
    x_l   = longint'(dot_x_p2);
    y_l   = longint'(dot_y_p2);
    d_l   = longint'(dot_d_p2);
    x_sat = sat_u(x_l, SCR_W);
    y_sat = sat_u(y_l, SCR_W);
    d_sat = sat_u(d_l, SCR_W);
    x_d     = x_sat[SCR_W-1:0];
    y_d     = y_sat[SCR_W-1:0];
    depth_d = d_sat[SCR_W-1:0];
    // Inverting lets the downstream max-accumulator compute a MinIP.
    dens_d  = (mode_p2_q == MODE_INVERT) ? (8'd255 - dens_p2_q) : dens_p2_q;
    drop    = (mode_p2_q == MODE_THRESH) && (dens_p2_q < thr_p2_q);
`ifdef MIP_CLIP_EN
    if ((x_l < 0) || (x_l > longint'(SCR_X_MAX)) ||
        (y_l < 0) || (y_l > longint'(SCR_Y_MAX)))
      drop = 1'b1;
`endif
  end

`ifndef MIP_CLIP_EN
  logic unused_clip_bounds;
  assign unused_clip_bounds = |{SCR_X_MAX, SCR_Y_MAX};
`endif

  // ---- S3: output register and drop counter ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p3_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      depth_q  <= '0;
      dens_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (en) begin
        vld_p3_q <= vld_p2_q && !drop;
        if (vld_p2_q && !drop) begin
          x_q     <= x_d;
          y_q     <= y_d;
          depth_q <= depth_d;
          dens_q  <= dens_d;
        end
      end
      if (in_countClear)
        cnt_q <= '0;
      else if (en && vld_p2_q && drop && (cnt_q != {DROP_CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid       = vld_p3_q;
  assign out_screenPos_x = x_q;
  assign out_screenPos_y = y_q;
  assign out_depth       = depth_q;
  assign out_density     = dens_q;
  assign out_dropCount   = cnt_q;

endmodule

// File: tb/tb_mip_project_core.sv
module tb_mip_project_core;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       in_voxelPos;
  logic [7:0]        in_density;
  logic signed [7:0] mat [3][3];
  logic [1:0]        in_mode;
  logic [7:0]        in_threshold;
  logic              in_countClear;
  logic              out_valid;
  logic              out_ready;
  logic [10:0]       out_screenPos_x;
  logic [10:0]       out_screenPos_y;
  logic [10:0]       out_depth;
  logic [7:0]        out_density;
  logic [15:0]       out_dropCount;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mip_project_core dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_voxelPos(in_voxelPos), .in_density(in_density),
    .in_mvpInfo_mat_0_0(mat[0][0]), .in_mvpInfo_mat_0_1(mat[0][1]), .in_mvpInfo_mat_0_2(mat[0][2]),
    .in_mvpInfo_mat_1_0(mat[1][0]), .in_mvpInfo_mat_1_1(mat[1][1]), .in_mvpInfo_mat_1_2(mat[1][2]),
    .in_mvpInfo_mat_2_0(mat[2][0]), .in_mvpInfo_mat_2_1(mat[2][1]), .in_mvpInfo_mat_2_2(mat[2][2]),
    .in_mode(in_mode), .in_threshold(in_threshold), .in_countClear(in_countClear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_screenPos_x(out_screenPos_x), .out_screenPos_y(out_screenPos_y),
    .out_depth(out_depth), .out_density(out_density), .out_dropCount(out_dropCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_identity();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mat[r][c] = (r == c) ? 8'sd64 : 8'sd0;
  endtask

  task automatic drive(input int v, input int x, input int y, input int z,
                       input int d, input int md, input int thr);
    in_valid     = v[0];
    in_voxelPos  = {8'(z), 8'(y), 8'(x)};
    in_density   = 8'(d);
    in_mode      = 2'(md);
    in_threshold = 8'(thr);
  endtask

  task automatic clear_count();
    in_countClear = 1'b1;
    step();
    in_countClear = 1'b0;
  endtask

  int nout;
  int sent;
  int recv;
  int extra;
  logic [7:0] seen [4];
  logic [7:0] hold_dens;
  logic [10:0] hold_x;
  logic stall;

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    in_countClear = 1'b0;
    set_identity();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_out_valid_during", out_valid, 0);
    reset = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", out_screenPos_x, 0);
    chk("rst_y", out_screenPos_y, 0);
    chk("rst_depth", out_depth, 0);
    chk("rst_density", out_density, 0);
    chk("rst_dropcount", out_dropCount, 0);
    chk("rst_in_ready", in_ready, 1);

    // Identity transform, latency 3.
    drive(1, 10, 20, 30, 200, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("lat_not_early", out_valid, 0);
    step();
    chk("id_valid", out_valid, 1);
    chk("id_x", out_screenPos_x, 10);
    chk("id_y", out_screenPos_y, 20);
    chk("id_depth", out_depth, 30);
    chk("id_density", out_density, 200);
    step();
    chk("id_single_beat", out_valid, 0);

    // Negative x: saturate (or clip when enabled).
    clear_count();
    mat[0][0] = -8'sd64;
    drive(1, 5, 20, 30, 7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
`ifdef MIP_CLIP_EN
    chk("clip_no_output", out_valid, 0);
    chk("clip_dropcount", out_dropCount, 1);
`else
    chk("neg_valid", out_valid, 1);
    chk("neg_x_sat0", out_screenPos_x, 0);
    chk("neg_y", out_screenPos_y, 20);
    chk("neg_dropcount", out_dropCount, 0);
`endif
    set_identity();
    step();

    // Threshold mode: 99 dropped, 100 and 101 pass.
    clear_count();
    nout = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) drive(1, 1, 2, 3, 99 + i, 1, 100);
      else       drive(0, 0, 0, 0, 0, 0, 0);
      step();
      if (out_valid) begin
        if (nout < 4) seen[nout] = out_density;
        nout++;
      end
    end
    chk("thr_num_outputs", nout, 2);
    chk("thr_first", seen[0], 100);
    chk("thr_second", seen[1], 101);
    chk("thr_dropcount", out_dropCount, 1);

    // Invert mode.
    drive(1, 1, 2, 3, 200, 2, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("inv_valid", out_valid, 1);
    chk("inv_density", out_density, 55);

    // Reserved mode 3 behaves as pass, even with a high threshold.
    drive(1, 1, 2, 3, 50, 3, 255);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("mode3_valid", out_valid, 1);
    chk("mode3_density", out_density, 50);
    step();

    // Stream of 8 beats with a 4-cycle output stall.
    sent = 0;
    recv = 0;
    hold_dens = '0;
    hold_x = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      stall = (cyc >= 4) && (cyc < 8);
      out_ready = !stall;
      if (sent < 8) drive(1, sent, 0, 0, sent + 1, 0, 0);
      else          drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (stall) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (cyc == 4) begin
          hold_dens = out_density;
          hold_x = out_screenPos_x;
        end else begin
          chk("stall_hold_density", out_density, hold_dens);
          chk("stall_hold_x", out_screenPos_x, hold_x);
        end
      end
      if (out_valid && out_ready) begin
        chk("stream_order_density", out_density, recv + 1);
        chk("stream_order_x", out_screenPos_x, recv);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stream_all_sent", sent, 8);
    chk("stream_all_recv", recv, 8);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) extra++;
    end
    chk("stream_no_dup", extra, 0);

    // Saturate the drop counter, then clear it during a drop.
    clear_count();
    drive(1, 0, 0, 0, 0, 1, 255);
    repeat (65540) step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("drop_saturated", out_dropCount, 16'hFFFF);
    chk("drop_no_output", out_valid, 0);
    in_countClear = 1'b1;
    step();
    in_countClear = 1'b0;
    chk("clear_wins_over_drop", out_dropCount, 0);
    step();
    chk("clear_stays_zero", out_dropCount, 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 40 + i, 0, 0, 10 + i, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("inflight_first_out", out_valid, 1);
    chk("inflight_first_density", out_density, 10);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_density", out_density, 0);
    step();
    step();
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) extra++;
    end
    chk("midrst_no_stale", extra, 0);
    chk("midrst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
